// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen: step/load controls in, state and period flags out.
interface lfsr_gen_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en_i;
  logic             load_i;
  logic [WIDTH-1:0] seed_i;
  logic [WIDTH-1:0] lfsr_o;
  logic             bit_o;
  logic             wrap_o;
  logic             lockup_o;
  logic [WIDTH-1:0] period_o;
  logic             period_vld_o;

  modport master (
    output en_i, load_i, seed_i,
    input  lfsr_o, bit_o, wrap_o, lockup_o, period_o, period_vld_o
  );

  modport slave (
    input  en_i, load_i, seed_i,
    output lfsr_o, bit_o, wrap_o, lockup_o, period_o, period_vld_o
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with runtime seed load, all-zero lock-up recovery
// and measurement of the sequence period back to its start value.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic     clk,
  input  logic     reset,
  lfsr_gen_if.slave bus
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_vld;
  logic             r_wrap;
  logic             r_lockup;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_cnt_inc;

  always_comb begin
    w_fb      = ^(r_state & TAPS);
    w_next    = {r_state[WIDTH-2:0], w_fb};
    w_cnt_inc = r_cnt + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= SEED;
      r_start  <= SEED;
      r_cnt    <= '0;
      r_period <= '0;
      r_vld    <= 1'b0;
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
      if (bus.load_i) begin
        r_state <= bus.seed_i;
        r_start <= bus.seed_i;
        r_cnt   <= '0;
        r_vld   <= 1'b0;
      end else if (bus.en_i) begin
        if (r_state == '0) begin
          // All-zero is a fixed point of the XOR feedback; restart from SEED.
          r_state  <= SEED;
          r_start  <= SEED;
          r_cnt    <= '0;
          r_lockup <= 1'b1;
        end else begin
          r_state <= w_next;
          if (w_next == r_start) begin
            r_wrap   <= 1'b1;
            r_period <= w_cnt_inc;
            r_vld    <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      end
    end
  end

  assign bus.lfsr_o       = r_state;
  assign bus.bit_o        = r_state[WIDTH-1];
  assign bus.wrap_o       = r_wrap;
  assign bus.lockup_o     = r_lockup;
  assign bus.period_o     = r_period;
  assign bus.period_vld_o = r_vld;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: 4-bit instance checked cycle by cycle against a scoreboard,
// default 8-bit instance free-run for period and uniqueness.
module tb_lfsr_gen;

  logic clk;
  logic reset;

  lfsr_gen_if #(.WIDTH(4)) bus4 ();
  lfsr_gen_if #(.WIDTH(8)) bus8 ();

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  lfsr_gen u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lfsr;
    logic       wrap;
    logic       lockup;
    logic [3:0] period;
    logic       vld;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_state, m_start, m_cnt, m_period;
  logic       m_vld, m_wrap, m_lock;

  logic [3:0] obs;
  logic [3:0] seq1 [15];
  int         last_wrap, n_wraps, n_lock, n_rep;
  bit         seen [256];
  logic [7:0] s8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic model_reset();
    m_state  = 4'h1;
    m_start  = 4'h1;
    m_cnt    = '0;
    m_period = '0;
    m_vld    = 1'b0;
  endtask

  // Drive one cycle on the 4-bit DUT, predict, then compare after the edge.
  task automatic step4(input logic en, input logic load, input logic [3:0] seed,
                       output logic [3:0] o);
    exp_t       e;
    logic [3:0] n;
    bus4.en_i   = en;
    bus4.load_i = load;
    bus4.seed_i = seed;
    m_wrap = 1'b0;
    m_lock = 1'b0;
    if (load) begin
      m_state = seed;
      m_start = seed;
      m_cnt   = '0;
      m_vld   = 1'b0;
    end else if (en) begin
      if (m_state == 4'h0) begin
        m_state = 4'h1;
        m_start = 4'h1;
        m_cnt   = '0;
        m_lock  = 1'b1;
      end else begin
        n = ref_next(m_state);
        m_cnt = m_cnt + 4'd1;
        if (n == m_start) begin
          m_wrap   = 1'b1;
          m_period = m_cnt;
          m_vld    = 1'b1;
          m_cnt    = '0;
        end
        m_state = n;
      end
    end
    e.lfsr   = m_state;
    e.wrap   = m_wrap;
    e.lockup = m_lock;
    e.period = m_period;
    e.vld    = m_vld;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("lfsr4", 32'(bus4.lfsr_o), 32'(e.lfsr));
    check("bit4", 32'(bus4.bit_o), 32'(e.lfsr[3]));
    check("wrap4", 32'(bus4.wrap_o), 32'(e.wrap));
    check("lockup4", 32'(bus4.lockup_o), 32'(e.lockup));
    check("period4", 32'(bus4.period_o), 32'(e.period));
    check("vld4", 32'(bus4.period_vld_o), 32'(e.vld));
    o = bus4.lfsr_o;
    bus4.en_i   = 1'b0;
    bus4.load_i = 1'b0;
  endtask

  initial begin
    seq1 = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
             4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    reset = 1'b1;
    bus4.en_i = 1'b0; bus4.load_i = 1'b0; bus4.seed_i = '0;
    bus8.en_i = 1'b0; bus8.load_i = 1'b0; bus8.seed_i = '0;
    model_reset();
    #12;
    reset = 1'b0;
    check("rst_lfsr4", 32'(bus4.lfsr_o), 32'h1);
    check("rst_bit4", 32'(bus4.bit_o), 32'h0);
    check("rst_flags4", {bus4.wrap_o, bus4.lockup_o, bus4.period_vld_o}, 32'h0);
    check("rst_period4", 32'(bus4.period_o), 32'h0);
    check("rst_lfsr8", 32'(bus8.lfsr_o), 32'h01);
    check("rst_period8", {bus8.period_o, bus8.period_vld_o}, 32'h0);
    @(posedge clk);
    #1;

    // Default config free-run: period 255, no repeats, no lock-up.
    last_wrap = 0; n_wraps = 0; n_lock = 0; n_rep = 0;
    foreach (seen[k]) seen[k] = 1'b0;
    seen[1] = 1'b1;
    bus8.en_i = 1'b1;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      s8 = bus8.lfsr_o;
      if (bus8.lockup_o) n_lock++;
      if (bus8.wrap_o) begin
        n_wraps++;
        check("wrap8_gap", 32'(i - last_wrap), 32'd255);
        check("wrap8_state", 32'(s8), 32'h01);
        check("period8", 32'(bus8.period_o), 32'd255);
        check("vld8", 32'(bus8.period_vld_o), 32'd1);
        last_wrap = i;
        foreach (seen[k]) seen[k] = 1'b0;
        seen[s8] = 1'b1;
      end else begin
        if (seen[s8]) n_rep++;
        seen[s8] = 1'b1;
      end
    end
    bus8.en_i = 1'b0;
    check("wraps8", 32'(n_wraps), 32'd2);
    check("lockups8", 32'(n_lock), 32'd0);
    check("repeats8", 32'(n_rep), 32'd0);

    // 4-bit: fresh reset, then 15 enabled steps through the full sequence.
    reset = 1'b1;
    #4;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      step4(1'b1, 1'b0, 4'h0, obs);
      check("seq1", 32'(obs), 32'(seq1[i]));
    end
    check("wrap_end1", {bus4.wrap_o, bus4.period_vld_o}, 32'h3);
    check("period_end1", 32'(bus4.period_o), 32'd15);

    // Gated enable from reset: 1,0,0,1.
    reset = 1'b1;
    #4;
    reset = 1'b0;
    model_reset();
    step4(1'b1, 1'b0, 4'h0, obs); check("gate0", 32'(obs), 32'h2);
    step4(1'b0, 1'b0, 4'h0, obs); check("gate1", 32'(obs), 32'h2);
    step4(1'b0, 1'b0, 4'h0, obs); check("gate2", 32'(obs), 32'h2);
    step4(1'b1, 1'b0, 4'h0, obs); check("gate3", 32'(obs), 32'h4);
    for (int i = 0; i < 13; i++) step4(1'b1, 1'b0, 4'h0, obs);
    check("gate_wrap", {bus4.wrap_o, bus4.period_vld_o}, 32'h3);
    check("gate_period", 32'(bus4.period_o), 32'd15);

    // Load takes priority over enable.
    step4(1'b1, 1'b1, 4'hA, obs);
    check("load_val", 32'(obs), 32'hA);
    check("load_vld", 32'(bus4.period_vld_o), 32'h0);
    step4(1'b1, 1'b0, 4'h0, obs); check("load_s1", 32'(obs), 32'h5);
    step4(1'b1, 1'b0, 4'h0, obs); check("load_s2", 32'(obs), 32'hB);
    step4(1'b1, 1'b0, 4'h0, obs); check("load_s3", 32'(obs), 32'h7);
    for (int i = 0; i < 12; i++) step4(1'b1, 1'b0, 4'h0, obs);
    check("load_wrap_val", 32'(obs), 32'hA);
    check("load_wrap", 32'(bus4.wrap_o), 32'h1);
    check("load_period", 32'(bus4.period_o), 32'd15);

    // Zero seed, then lock-up recovery on the next enabled step.
    step4(1'b0, 1'b1, 4'h0, obs);
    check("zero_val", 32'(obs), 32'h0);
    step4(1'b1, 1'b0, 4'h0, obs);
    check("recov_val", 32'(obs), 32'h1);
    check("recov_lock", {bus4.lockup_o, bus4.wrap_o}, 32'h2);
    check("recov_period", 32'(bus4.period_o), 32'd15);
    for (int i = 0; i < 15; i++) step4(1'b1, 1'b0, 4'h0, obs);
    check("recov_wrap", {bus4.wrap_o, bus4.period_vld_o}, 32'h3);
    check("recov_wperiod", 32'(bus4.period_o), 32'd15);

    // Run to D, then assert reset mid-cycle.
    for (int i = 0; i < 6; i++) step4(1'b1, 1'b0, 4'h0, obs);
    check("pre_rst", 32'(obs), 32'hD);
    #1;
    reset = 1'b1;
    #1;
    check("async_lfsr", 32'(bus4.lfsr_o), 32'h1);
    check("async_flags", {bus4.wrap_o, bus4.lockup_o, bus4.period_vld_o}, 32'h0);
    check("async_period", 32'(bus4.period_o), 32'h0);
    #4;
    reset = 1'b0;
    model_reset();
    step4(1'b1, 1'b0, 4'h0, obs);
    check("post_rst", 32'(obs), 32'h2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci linear feedback shift register for pseudo-random stimulus and scrambler-seed generation. It generalises the fixed 4-bit LFSR to:
- any width from 3 to 32 bits, with a parameter tap mask;
- runtime seed load and a step enable;
- all-zero lock-up recovery;
- a period measurement that flags when the sequence returns to its start value.

It sits on the datapath as a free-running or gated pattern source.

## Interface
- WIDTH, 8, register width in bits (legal range 3..32)
- TAPS, 8'hB8, feedback tap mask, WIDTH bits; bit i set means state[i] feeds the XOR (default is x^8+x^6+x^5+x^4+1)
- SEED, 8'h01, reset and lock-up recovery value, WIDTH bits; must be nonzero
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- en_i  in  1  advance the LFSR one step this cycle
- load_i  in  1  load seed_i into the state this cycle
- seed_i  in  WIDTH  runtime seed; sampled only when load_i=1
- lfsr_o  out  WIDTH  current LFSR state (registered)
- bit_o  out  1  serial output, equal to lfsr_o[WIDTH-1]
- wrap_o  out  1  one-cycle pulse when the state returns to the start value
- lockup_o  out  1  one-cycle pulse when an all-zero state was replaced by SEED
- period_o  out  WIDTH  step count of the last completed cycle (registered)
- period_vld_o  out  1  period_o holds a valid measurement

## Operation
- Feedback: fb = XOR-reduce(state & TAPS). Step: next = {state[WIDTH-2:0], fb} (shift left, fb enters the LSB).
- Internal registers:
  - start_r: WIDTH bits, the value the current sequence began from.
  - cnt_r: WIDTH bits, steps taken since start_r was set.
- Priority per rising edge: reset > load_i > en_i.
- Load (load_i=1, regardless of en_i): state <= seed_i, start_r <= seed_i, cnt_r <= 0, period_vld_o <= 0. No step is taken; wrap_o and lockup_o are 0 that cycle.
- Step (en_i=1, load_i=0, state nonzero):
  - state <= next, cnt_r <= cnt_r+1.
  - If next == start_r: wrap_o <= 1, period_o <= cnt_r+1, period_vld_o <= 1, cnt_r <= 0.
- Lock-up (en_i=1, load_i=0, state == 0):
  - state <= SEED, start_r <= SEED, cnt_r <= 0, lockup_o <= 1, wrap_o <= 0.
  - period_o and period_vld_o are unchanged.
- Idle (en_i=0, load_i=0): every register holds; wrap_o and lockup_o are 0.
- A zero seed_i is accepted. The state stays 0 until the next enabled step, which triggers recovery.
- cnt_r width: a maximal-length sequence has period 2^WIDTH-1, which fits in WIDTH bits. With a non-primitive TAPS, cnt_r wraps modulo 2^WIDTH and period_o is undefined. No overflow flag is produced.

## Timing
- Reset values: lfsr_o=SEED, bit_o=SEED[WIDTH-1], start_r=SEED, cnt_r=0, wrap_o=0, lockup_o=0, period_o=0, period_vld_o=0.
- Reset takes effect asynchronously, immediately on assertion, including mid-sequence. Release is synchronised externally.
- Latency: lfsr_o reflects a step or load one cycle after en_i/load_i is sampled high.
- bit_o is combinational from the state register, so it has the same timing as lfsr_o.
- wrap_o is high in exactly the cycle in which lfsr_o first shows start_r again.
- lockup_o is high in the cycle in which lfsr_o first shows SEED after recovery.
- Back-to-back enabled cycles step every cycle; there is no throughput bubble.
- period_o and period_vld_o update in the same cycle as wrap_o.

## Test plan
- WIDTH=4, TAPS=4'hC, SEED=4'h1: reset, then en_i=1 for 15 cycles.
  - lfsr_o = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
  - wrap_o pulses only in the cycle showing the final 1.
  - Same cycle: period_o=15, period_vld_o=1.
- Same config, en_i gated: toggle en_i 1,0,0,1 from reset.
  - lfsr_o = 2,2,2,4.
  - cnt_r is unaffected in the idle cycles; wrap still occurs after 15 enabled steps.
- Same config, load while enabled: load_i=1 with seed_i=4'hA and en_i=1.
  - Next lfsr_o=A, period_vld_o=0.
  - Following steps give 5,B,7,…; wrap_o occurs 15 steps later at A with period_o=15.
- Same config, zero seed: load seed_i=0, then en_i=1.
  - lfsr_o=0, then 1.
  - lockup_o pulses once, wrap_o stays 0, period_o is unchanged.
  - The next 15 steps produce a wrap with period_o=15.
- Reset mid-run: assert reset 2 ns after a rising edge while lfsr_o=D.
  - lfsr_o=1 before the next edge; all flags 0; period_vld_o=0.
- Defaults (WIDTH=8, TAPS=8'hB8, SEED=8'h01): free-run for 600 cycles.
  - wrap_o pulses every 255 cycles, period_o=255.
  - No state repeats within a period; lockup_o is never asserted.
